// File: rtl/mux16_demux_pkg.sv
// ============================================================================
// Module : mux16_demux_pkg
// Brief  : Shared defaults, FSM state type and full-mask constant for the
//          16:1 select-mux frame demultiplexer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mux16_demux_pkg;

    localparam int DEF_N_CH  = 16;
    localparam int DEF_SEL_W = 4;

    typedef enum logic [0:0] {
        FILL  = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam logic [DEF_N_CH-1:0] c_MASK_FULL = {DEF_N_CH{1'b1}};

endpackage

`default_nettype wire

// File: rtl/mux16_frame_demux_if.sv
// ============================================================================
// Module : mux16_frame_demux_if
// Brief  : Muxed-line input, frame output handshake and error pulses.
//          master = line source / frame sink, slave = the demultiplexer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface mux16_frame_demux_if
    import mux16_demux_pkg::*;
#(
    parameter int N_CH  = DEF_N_CH,
    parameter int SEL_W = DEF_SEL_W
);
    logic             line_en_n;
    logic             line_bit;
    logic [SEL_W-1:0] line_sel;
    logic             line_rdy;
    logic [N_CH-1:0]  out_data;
    logic             out_valid;
    logic             out_ready;
    logic             err_dup;
    logic             err_drop;
    logic             err_timeout;

    modport master (
        output line_en_n, line_bit, line_sel, out_ready,
        input  line_rdy, out_data, out_valid, err_dup, err_drop, err_timeout
    );

    modport slave (
        input  line_en_n, line_bit, line_sel, out_ready,
        output line_rdy, out_data, out_valid, err_dup, err_drop, err_timeout
    );
endinterface

`default_nettype wire

// File: rtl/demux_slot_collector.sv
// ============================================================================
// Module : demux_slot_collector
// Brief  : Collect register and fill mask; inserts one bit per accepted
//          sample and flags the sample that completes the frame.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module demux_slot_collector
    import mux16_demux_pkg::*;
#(
    parameter int N_CH  = DEF_N_CH,
    parameter int SEL_W = DEF_SEL_W
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_insert,
    input  wire logic [SEL_W-1:0] i_sel,
    input  wire logic             i_bit,
    input  wire logic             i_clear,
    output logic      [N_CH-1:0]  o_collect,
    output logic      [N_CH-1:0]  o_collect_next,
    output logic                  o_hit,
    output logic                  o_mask_any,
    output logic                  o_complete
);
    localparam logic [N_CH-1:0] c_FULL = {N_CH{1'b1}};

    logic [N_CH-1:0] r_collect;
    logic [N_CH-1:0] r_mask;
    logic [N_CH-1:0] w_mask_next;

    always_comb begin
        o_collect_next = r_collect;
        w_mask_next    = r_mask;
        if (i_insert) begin
            o_collect_next[i_sel] = i_bit;
            w_mask_next[i_sel]    = 1'b1;
        end
    end

    assign o_collect  = r_collect;
    assign o_hit      = r_mask[i_sel];
    assign o_mask_any = |r_mask;
    assign o_complete = i_insert && (w_mask_next == c_FULL);

    // Clear beats insert: the completing sample is already carried out via o_collect_next.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_collect <= '0;
            r_mask    <= '0;
        end else begin
            r_collect <= o_collect_next;
            r_mask    <= w_mask_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mux16_frame_demux.sv
// ============================================================================
// Module : mux16_frame_demux
// Brief  : Rebuilds parallel frames from a 16:1 select-muxed serial line.
//          Optional partial-frame timeout: MUX16_FRAME_DEMUX_TIMEOUT_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mux16_frame_demux
    import mux16_demux_pkg::*;
#(
    parameter int N_CH    = DEF_N_CH,
    parameter int SEL_W   = DEF_SEL_W,
    parameter int TIMEOUT = 64
) (
    input wire logic               clk,
    input wire logic               rst,
    mux16_frame_demux_if.slave     bus
);
    state_t          r_state;
    state_t          w_state_next;
    logic            w_accept;
    logic            w_xfer;
    logic            w_out_free;
    logic            w_load;
    logic [N_CH-1:0] w_load_data;
    logic            w_clear;
    logic            w_timeout;
    logic            w_hit;
    logic            w_mask_any;
    logic            w_complete;
    logic [N_CH-1:0] w_collect;
    logic [N_CH-1:0] w_collect_next;

    logic [N_CH-1:0] r_out_data;
    logic            r_out_valid;
    logic            r_err_dup;
    logic            r_err_drop;

    demux_slot_collector #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_collector (
        .clk            (clk),
        .rst            (rst),
        .i_insert       (w_accept),
        .i_sel          (bus.line_sel),
        .i_bit          (bus.line_bit),
        .i_clear        (w_clear),
        .o_collect      (w_collect),
        .o_collect_next (w_collect_next),
        .o_hit          (w_hit),
        .o_mask_any     (w_mask_any),
        .o_complete     (w_complete)
    );

    assign w_xfer     = r_out_valid && bus.out_ready;
    assign w_out_free = !r_out_valid || bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) r_state <= FILL;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FILL:    if (w_complete && !w_out_free) w_state_next = STALL;
            STALL:   if (w_xfer)                    w_state_next = FILL;
            default: w_state_next = FILL;
        endcase
    end

    always_comb begin
        w_accept    = 1'b0;
        w_load      = 1'b0;
        w_load_data = w_collect_next;
        bus.line_rdy = 1'b0;
        case (r_state)
            FILL: begin
                bus.line_rdy = 1'b1;
                w_accept     = !bus.line_en_n;
                w_load       = w_complete && w_out_free;
            end
            STALL: begin
                w_load      = w_xfer;
                w_load_data = w_collect;
            end
            default: ;
        endcase
        w_clear = w_load || w_timeout;
    end

    // A load in the same cycle as a transfer keeps out_valid high (back-to-back).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_err_dup   <= 1'b0;
            r_err_drop  <= 1'b0;
        end else begin
            if (w_load) begin
                r_out_data  <= w_load_data;
                r_out_valid <= 1'b1;
            end else if (w_xfer) begin
                r_out_valid <= 1'b0;
            end
            r_err_dup  <= w_accept && w_hit;
            r_err_drop <= (r_state == STALL) && !bus.line_en_n;
        end
    end

    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.err_dup   = r_err_dup;
    assign bus.err_drop  = r_err_drop;

`ifdef MUX16_FRAME_DEMUX_TIMEOUT_EN
    localparam int              TMR_W      = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] c_TMR_LAST = TMR_W'(TIMEOUT - 1);

    logic [TMR_W-1:0] r_tmr;
    logic             r_err_timeout;

    // Completion needs an accepted sample, so it can never coincide with a timeout.
    assign w_timeout = (r_state == FILL) && !w_accept && w_mask_any && (r_tmr == c_TMR_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmr         <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            r_err_timeout <= w_timeout;
            if (r_state == FILL) begin
                if (w_accept || w_timeout) r_tmr <= '0;
                else if (w_mask_any)       r_tmr <= r_tmr + 1'b1;
            end
        end
    end

    assign bus.err_timeout = r_err_timeout;
`else
    assign w_timeout       = 1'b0;
    assign bus.err_timeout = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux16_frame_demux.sv
// ============================================================================
// Module : tb_mux16_frame_demux
// Brief  : Directed self-checking bench for mux16_frame_demux.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_mux16_frame_demux;
    import mux16_demux_pkg::*;

    localparam int c_TMO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    int   cnt_dup  = 0;
    int   cnt_drop = 0;
    int   cnt_to   = 0;
    logic [15:0] q[$];

    mux16_frame_demux_if #(.N_CH(16), .SEL_W(4)) bus ();

    mux16_frame_demux #(
        .N_CH    (16),
        .SEL_W   (4),
        .TIMEOUT (c_TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Frames are logged on the negedge preceding the posedge that transfers them.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid && bus.out_ready) q.push_back(bus.out_data);
            if (bus.err_dup)     cnt_dup++;
            if (bus.err_drop)    cnt_drop++;
            if (bus.err_timeout) cnt_to++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int s, input logic b);
        bus.line_en_n = 1'b0;
        bus.line_sel  = 4'(s);
        bus.line_bit  = b;
        step();
    endtask

    task automatic idle(input int n);
        bus.line_en_n = 1'b1;
        repeat (n) step();
    endtask

    task automatic send_frame(input logic [15:0] v, input bit rev);
        for (int i = 0; i < 16; i++) begin
            int s;
            s = rev ? 15 - i : i;
            send(s, v[s]);
        end
    endtask

    task automatic clr();
        q.delete();
        cnt_dup  = 0;
        cnt_drop = 0;
        cnt_to   = 0;
    endtask

    initial begin
        logic [15:0] v;
        bus.line_en_n = 1'b1;
        bus.line_bit  = 1'b0;
        bus.line_sel  = '0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) step();
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_data",  32'(bus.out_data),  32'd0);
        check("rst_rdy",   32'(bus.line_rdy),  32'd1);
        check("rst_errs",  32'({bus.err_dup, bus.err_drop, bus.err_timeout}), 32'd0);
        rst = 1'b0;
        idle(1);

        // In-order frame, one-cycle latency
        clr();
        v = 16'hA5C3;
        for (int k = 0; k < 16; k++) begin
            if (k == 15) check("t1_no_early_valid", 32'(bus.out_valid), 32'd0);
            if (bus.line_rdy !== 1'b1) check("t1_rdy", 32'(bus.line_rdy), 32'd1);
            send(k, v[k]);
        end
        check("t1_valid", 32'(bus.out_valid), 32'd1);
        check("t1_data",  32'(bus.out_data),  32'hA5C3);
        idle(2);
        check("t1_valid_drop", 32'(bus.out_valid), 32'd0);
        check("t1_qsize", 32'(q.size()), 32'd1);
        if (q.size() > 0) check("t1_q0", 32'(q[0]), 32'hA5C3);

        // Reverse frame then forward frame, no gap
        clr();
        send_frame(16'h1234, 1'b1);
        check("t2_f1_valid", 32'(bus.out_valid), 32'd1);
        check("t2_f1_data",  32'(bus.out_data),  32'h1234);
        send(0, 1'b1);
        check("t2_mid_valid", 32'(bus.out_valid), 32'd0);
        for (int k = 1; k < 16; k++) send(k, 1'b1);
        check("t2_f2_valid", 32'(bus.out_valid), 32'd1);
        check("t2_f2_data",  32'(bus.out_data),  32'hFFFF);
        check("t2_rdy",      32'(bus.line_rdy),  32'd1);
        idle(2);
        check("t2_qsize", 32'(q.size()), 32'd2);
        if (q.size() > 1) begin
            check("t2_q0", 32'(q[0]), 32'h1234);
            check("t2_q1", 32'(q[1]), 32'hFFFF);
        end

        // Duplicate slot
        clr();
        send(3, 1'b1);
        check("t3_no_dup_first", 32'(bus.err_dup), 32'd0);
        send(3, 1'b0);
        check("t3_dup_pulse", 32'(bus.err_dup), 32'd1);
        for (int k = 0; k < 16; k++) if (k != 3) send(k, 1'b1);
        idle(2);
        check("t3_dup_count", 32'(cnt_dup), 32'd1);
        check("t3_qsize", 32'(q.size()), 32'd1);
        if (q.size() > 0) check("t3_data", 32'(q[0]), 32'hFFF7);

        // Stall with held output
        clr();
        bus.out_ready = 1'b0;
        send_frame(16'h1111, 1'b0);
        check("t4_f1_valid", 32'(bus.out_valid), 32'd1);
        check("t4_rdy_fill", 32'(bus.line_rdy),  32'd1);
        send_frame(16'h2222, 1'b0);
        check("t4_rdy_stall", 32'(bus.line_rdy), 32'd0);
        send(0, 1'b1);
        send(1, 1'b1);
        bus.line_en_n = 1'b1;
        check("t4_hold_data", 32'(bus.out_data), 32'h1111);
        check("t4_hold_rdy",  32'(bus.line_rdy), 32'd0);
        bus.out_ready = 1'b1;
        idle(1);
        check("t4_drop_count", 32'(cnt_drop), 32'd2);
        check("t4_f2_valid",   32'(bus.out_valid), 32'd1);
        check("t4_f2_data",    32'(bus.out_data),  32'h2222);
        check("t4_rdy_back",   32'(bus.line_rdy),  32'd1);
        idle(2);
        check("t4_qsize", 32'(q.size()), 32'd2);
        if (q.size() > 1) begin
            check("t4_q0", 32'(q[0]), 32'h1111);
            check("t4_q1", 32'(q[1]), 32'h2222);
        end

        // Reset mid-frame
        clr();
        for (int k = 0; k < 7; k++) send(k, 1'b1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("t5_valid", 32'(bus.out_valid), 32'd0);
        check("t5_rdy",   32'(bus.line_rdy),  32'd1);
        send_frame(16'h0F0F, 1'b0);
        check("t5_data", 32'(bus.out_data), 32'h0F0F);
        idle(2);
        check("t5_qsize", 32'(q.size()), 32'd1);
        check("t5_dup",   32'(cnt_dup),  32'd0);

`ifdef MUX16_FRAME_DEMUX_TIMEOUT_EN
        // Partial-frame timeout
        clr();
        for (int k = 0; k < 5; k++) send(k, 1'b1);
        idle(7);
        check("t6_no_early_to", 32'(bus.err_timeout), 32'd0);
        idle(1);
        check("t6_to_pulse", 32'(bus.err_timeout), 32'd1);
        idle(3);
        check("t6_to_count", 32'(cnt_to), 32'd1);
        send_frame(16'hBEEF, 1'b0);
        idle(2);
        check("t6_dup",   32'(cnt_dup),  32'd0);
        check("t6_qsize", 32'(q.size()), 32'd1);
        if (q.size() > 0) check("t6_data", 32'(q[0]), 32'hBEEF);
`else
        // Long idle with a partial frame: nothing times out
        clr();
        for (int k = 0; k < 5; k++) send(k, 1'b1);
        idle(c_TMO * 10);
        check("t6_no_timeout", 32'(cnt_to), 32'd0);
        for (int k = 5; k < 16; k++) send(k, 1'b0);
        check("t6_late_data", 32'(bus.out_data), 32'h001F);
        idle(2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

`default_nettype wire
